// File: rtl/dsp_core_if.sv
// Memory-side bus of the DSP execution core.
// The core drives the access request (enable_M, addr_M, wr_data_M) and
// the memory answers with ready_M and, for reads, rd_data_M.
//   enable_M  : 2'b01 read, 2'b10 write, 2'b00 idle
//   addr_M    : access address
//   wr_data_M : store data (zero when no write is in progress)
//   rd_data_M : load data, valid together with ready_M
//   ready_M   : access complete
interface dsp_core_if #(
    parameter int unsigned REG_SIZE  = 8,
    parameter int unsigned ADDR_SIZE = 8
);
    logic [REG_SIZE-1:0]  rd_data_M;
    logic                 ready_M;
    logic [REG_SIZE-1:0]  wr_data_M;
    logic [ADDR_SIZE-1:0] addr_M;
    logic [1:0]           enable_M;

    modport master (
        input  rd_data_M,
        input  ready_M,
        output wr_data_M,
        output addr_M,
        output enable_M
    );

    modport slave (
        output rd_data_M,
        output ready_M,
        input  wr_data_M,
        input  addr_M,
        input  enable_M
    );
endinterface

// File: rtl/dsp_core.sv
// Multi-cycle (non-pipelined) DSP execution core.
// A Start pulse in IDLE captures an instruction block (and optionally seeds
// R0), then instructions run from slot 0, one per cycle, until a READY
// instruction or PC overflow. Loads and stores go through the handshake
// bus in dsp_core_if and stall in MEM until ready_M.
// Ports:
//   clk          : clock, rising edge
//   reset        : synchronous, active-low
//   init_R0_flag : load R0 from init_R0_data on accepted Start
//   init_R0_data : R0 seed value
//   insn_data    : instruction block, slot i at [(i+1)*INSN_SIZE-1 : i*INSN_SIZE]
//   Start        : begin execution (only sampled in IDLE)
//   Ready        : core idle / finished
//   mem          : memory bus (master side)
module dsp_core #(
    parameter int unsigned REG_SIZE   = 8,
    parameter int unsigned ADDR_SIZE  = 8,
    parameter int unsigned INSN_SIZE  = 16,
    parameter int unsigned INSN_COUNT = 16,
    parameter int unsigned REG_COUNT  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            init_R0_flag,
    input  logic [REG_SIZE-1:0]             init_R0_data,
    input  logic [INSN_COUNT*INSN_SIZE-1:0] insn_data,
    input  logic                            Start,
    output logic                            Ready,
    dsp_core_if.master                      mem
);
    localparam int unsigned PCW   = $clog2(INSN_COUNT);
    localparam int unsigned SUM_W = (ADDR_SIZE > REG_SIZE) ? ADDR_SIZE : REG_SIZE;
    localparam logic [PCW:0] PC_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MEM
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_MUL   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_CMPGE = 4'h7;
    localparam logic [3:0] OP_LDI   = 4'h8;
    localparam logic [3:0] OP_LD    = 4'h9;
    localparam logic [3:0] OP_ST    = 4'hA;
    localparam logic [3:0] OP_BNZ   = 4'hB;
    localparam logic [3:0] OP_READY = 4'hF;

    state_t state, state_next;

    // Extra top bit of pc flags running past the last slot.
    logic [PCW:0] pc, pc_next;

    logic [INSN_SIZE-1:0] ibuf [INSN_COUNT];
    logic [REG_SIZE-1:0]  rf   [REG_COUNT];

    logic                 ibuf_load;
    logic                 rf_we;
    logic [3:0]           rf_waddr;
    logic [REG_SIZE-1:0]  rf_wdata;
    logic [1:0]           en_next;
    logic [ADDR_SIZE-1:0] addr_next;
    logic [REG_SIZE-1:0]  wdata_next;

    // Decode of the current slot
    logic [INSN_SIZE-1:0]   insn;
    logic [3:0]             opcode, fd, fa, fb;
    logic [7:0]             imm8;
    logic [REG_SIZE-1:0]    ra, rb, rdv;
    logic [REG_SIZE-1:0]    alu;
    logic [2*REG_SIZE-1:0]  prod;
    logic [SUM_W-1:0]       ea_sum;
    logic [ADDR_SIZE-1:0]   ea;

    assign insn   = ibuf[pc[PCW-1:0]];
    assign opcode = insn[15:12];
    assign fd     = insn[11:8];
    assign fa     = insn[7:4];
    assign fb     = insn[3:0];
    assign imm8   = insn[7:0];
    assign ra     = rf[fa];
    assign rb     = rf[fb];
    assign rdv    = rf[fd];

    assign Ready  = (state == IDLE);

    always_comb begin
        prod   = (2*REG_SIZE)'(ra) * (2*REG_SIZE)'(rb);
        ea_sum = SUM_W'(ra) + SUM_W'(fb);
        ea     = ea_sum[ADDR_SIZE-1:0];
    end

    always_comb begin
        alu = '0;
        unique case (opcode)
            OP_ADD:   alu = ra + rb;
            OP_SUB:   alu = ra - rb;
            OP_MUL:   alu = prod[REG_SIZE-1:0];
            OP_AND:   alu = ra & rb;
            OP_OR:    alu = ra | rb;
            OP_XOR:   alu = ra ^ rb;
            OP_CMPGE: alu = REG_SIZE'(ra >= rb);
            OP_LDI:   alu = REG_SIZE'(imm8);
            default:  alu = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        ibuf_load  = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        en_next    = mem.enable_M;
        addr_next  = mem.addr_M;
        wdata_next = mem.wr_data_M;

        unique case (state)
            IDLE: begin
                if (Start) begin
                    ibuf_load  = 1'b1;
                    pc_next    = '0;
                    state_next = EXEC;
                    if (init_R0_flag) begin
                        rf_we    = 1'b1;
                        rf_waddr = '0;
                        rf_wdata = init_R0_data;
                    end
                end
            end

            EXEC: begin
                if (pc[PCW]) begin
                    state_next = IDLE;
                end else begin
                    unique case (opcode)
                        OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR,
                        OP_CMPGE, OP_LDI: begin
                            rf_we    = 1'b1;
                            rf_waddr = fd;
                            rf_wdata = alu;
                            pc_next  = pc + PC_ONE;
                        end
                        OP_LD: begin
                            en_next    = 2'b01;
                            addr_next  = ea;
                            wdata_next = '0;
                            state_next = MEM;
                        end
                        OP_ST: begin
                            en_next    = 2'b10;
                            addr_next  = ea;
                            wdata_next = rdv;
                            state_next = MEM;
                        end
                        OP_BNZ: begin
                            if (rdv != '0) begin
                                pc_next = {1'b0, imm8[PCW-1:0]};
                            end else begin
                                pc_next = pc + PC_ONE;
                            end
                        end
                        OP_READY: begin
                            state_next = IDLE;
                        end
                        default: begin
                            pc_next = pc + PC_ONE;
                        end
                    endcase
                end
            end

            MEM: begin
                // pc still points at the LD/ST, so fd names the load target.
                if (mem.ready_M) begin
                    if (mem.enable_M == 2'b01) begin
                        rf_we    = 1'b1;
                        rf_waddr = fd;
                        rf_wdata = mem.rd_data_M;
                    end
                    en_next    = '0;
                    wdata_next = '0;
                    pc_next    = pc + PC_ONE;
                    state_next = EXEC;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            pc           <= '0;
            mem.enable_M <= '0;
            mem.addr_M   <= '0;
            mem.wr_data_M <= '0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            mem.enable_M <= en_next;
            mem.addr_M   <= addr_next;
            mem.wr_data_M <= wdata_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                rf[i] <= '0;
            end
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < INSN_COUNT; i++) begin
                ibuf[i] <= '0;
            end
        end else if (ibuf_load) begin
            for (int unsigned i = 0; i < INSN_COUNT; i++) begin
                ibuf[i] <= insn_data[i*INSN_SIZE +: INSN_SIZE];
            end
        end
    end
endmodule

// File: tb/tb_dsp_core.sv
// Self-checking bench for dsp_core: a table of small programs with
// hand-computed memory traffic and cycle counts, plus directed sequences
// for Start while busy, Start at the Ready edge and reset during MEM.
module tb_dsp_core;
    logic             clk;
    logic             reset;
    logic             init_R0_flag;
    logic [7:0]       init_R0_data;
    logic [255:0]     insn_data;
    logic             Start;
    logic             Ready;

    dsp_core_if #(.REG_SIZE(8), .ADDR_SIZE(8)) mem_bus ();

    dsp_core #(
        .REG_SIZE(8),
        .ADDR_SIZE(8),
        .INSN_SIZE(16),
        .INSN_COUNT(16),
        .REG_COUNT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .init_R0_flag(init_R0_flag),
        .init_R0_data(init_R0_data),
        .insn_data(insn_data),
        .Start(Start),
        .Ready(Ready),
        .mem(mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0][15:0] prog;
        logic              seed_flag;
        logic [7:0]        seed;
        logic [7:0]        rd;
        int                lat;
        int                n_acc;
        logic [3:0][1:0]   en;
        logic [3:0][7:0]   addr;
        logic [3:0][7:0]   wd;
        int                cycles;
        logic [7:0]        last_addr;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_bus.enable_M != 2'b00) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic add_acc(input int vi, input int k, input logic [1:0] en,
                           input logic [7:0] a, input logic [7:0] d);
        vecs[vi].en[k]   = en;
        vecs[vi].addr[k] = a;
        vecs[vi].wd[k]   = d;
    endtask

    task automatic run_vec(input int vi);
        int         n;
        int         wc;
        int         cyc;
        logic [17:0] held;
        do_reset();
        insn_data    = vecs[vi].prog;
        init_R0_flag = vecs[vi].seed_flag;
        init_R0_data = vecs[vi].seed;
        Start        = 1'b1;
        tick();
        Start        = 1'b0;
        init_R0_flag = 1'b0;
        chk($sformatf("v%0d_busy", vi), {31'd0, Ready}, 32'd0);
        n    = 0;
        wc   = 0;
        cyc  = 0;
        held = '0;
        while (Ready == 1'b0 && cyc < 300) begin
            if (mem_bus.enable_M != 2'b00) begin
                if (wc == 0) begin
                    if (n < 4) begin
                        chk($sformatf("v%0d_acc%0d_en", vi, n),
                            {30'd0, mem_bus.enable_M}, {30'd0, vecs[vi].en[n]});
                        chk($sformatf("v%0d_acc%0d_addr", vi, n),
                            {24'd0, mem_bus.addr_M}, {24'd0, vecs[vi].addr[n]});
                        chk($sformatf("v%0d_acc%0d_wdata", vi, n),
                            {24'd0, mem_bus.wr_data_M}, {24'd0, vecs[vi].wd[n]});
                    end
                    held = {mem_bus.enable_M, mem_bus.addr_M, mem_bus.wr_data_M};
                    n++;
                end else begin
                    chk($sformatf("v%0d_hold", vi),
                        {14'd0, mem_bus.enable_M, mem_bus.addr_M, mem_bus.wr_data_M},
                        {14'd0, held});
                end
                mem_bus.ready_M   = (wc >= vecs[vi].lat);
                mem_bus.rd_data_M = vecs[vi].rd;
                wc++;
            end else begin
                mem_bus.ready_M = 1'b0;
                wc = 0;
            end
            tick();
            cyc++;
        end
        mem_bus.ready_M = 1'b0;
        chk($sformatf("v%0d_cycles", vi), cyc, vecs[vi].cycles);
        chk($sformatf("v%0d_n_acc", vi), n, vecs[vi].n_acc);
        chk($sformatf("v%0d_idle_en", vi), {30'd0, mem_bus.enable_M}, 32'd0);
        chk($sformatf("v%0d_idle_wdata", vi), {24'd0, mem_bus.wr_data_M}, 32'd0);
        chk($sformatf("v%0d_last_addr", vi), {24'd0, mem_bus.addr_M}, {24'd0, vecs[vi].last_addr});
    endtask

    initial begin
        bit ok;
        logic [255:0] all_ready;

        reset             = 1'b1;
        init_R0_flag      = 1'b0;
        init_R0_data      = '0;
        insn_data         = '0;
        Start             = 1'b0;
        mem_bus.ready_M   = 1'b0;
        mem_bus.rd_data_M = '0;

        for (int i = 0; i < NVEC; i++) vecs[i] = '{default: '0};

        // 0: single store from R0 (zero) to address 0
        vecs[0].prog[0] = 16'hA000; vecs[0].prog[1] = 16'hF000;
        vecs[0].n_acc = 1; vecs[0].cycles = 3;
        add_acc(0, 0, 2'b10, 8'h00, 8'h00);

        // 1: R0=3; LDI R1,5; ADD R2=R0+R1; CMPGE R3=R1>=R0; store R2, R3
        vecs[1].prog[0] = 16'h8105; vecs[1].prog[1] = 16'h1201;
        vecs[1].prog[2] = 16'h7310; vecs[1].prog[3] = 16'hA201;
        vecs[1].prog[4] = 16'hA302; vecs[1].prog[5] = 16'hF000;
        vecs[1].seed_flag = 1'b1; vecs[1].seed = 8'h03;
        vecs[1].n_acc = 2; vecs[1].cycles = 8; vecs[1].last_addr = 8'h05;
        add_acc(1, 0, 2'b10, 8'h04, 8'h08);
        add_acc(1, 1, 2'b10, 8'h05, 8'h01);

        // 2: R0=3; LD R1,[R0+2] with 5-cycle stall returning A5; ST R1@R0
        vecs[2].prog[0] = 16'h9102; vecs[2].prog[1] = 16'hA100;
        vecs[2].prog[2] = 16'hF000;
        vecs[2].seed_flag = 1'b1; vecs[2].seed = 8'h03;
        vecs[2].rd = 8'hA5; vecs[2].lat = 5;
        vecs[2].n_acc = 2; vecs[2].cycles = 15; vecs[2].last_addr = 8'h03;
        add_acc(2, 0, 2'b01, 8'h05, 8'h00);
        add_acc(2, 1, 2'b10, 8'h03, 8'hA5);

        // 3: wrap 255+255=254; seed data present but flag low, so R0 stays 0
        vecs[3].prog[0] = 16'h81FF; vecs[3].prog[1] = 16'h1111;
        vecs[3].prog[2] = 16'hA100; vecs[3].prog[3] = 16'hF000;
        vecs[3].seed = 8'h77;
        vecs[3].n_acc = 1; vecs[3].cycles = 5;
        add_acc(3, 0, 2'b10, 8'h00, 8'hFE);

        // 4: BNZ loop (target 0x13 mod 16 = 3) running 3 times, R5 counts
        vecs[4].prog[0] = 16'h8203; vecs[4].prog[1] = 16'h8401;
        vecs[4].prog[2] = 16'h8500; vecs[4].prog[3] = 16'h1554;
        vecs[4].prog[4] = 16'h2224; vecs[4].prog[5] = 16'hB213;
        vecs[4].prog[6] = 16'hA500; vecs[4].prog[7] = 16'hF000;
        vecs[4].n_acc = 1; vecs[4].cycles = 15;
        add_acc(4, 0, 2'b10, 8'h00, 8'h03);

        // 5: R0=0x1D, R1=0x0B: MUL 0x13F->3F, AND 09, OR 1F, XOR 16; 1-cycle memory wait
        vecs[5].prog[0] = 16'h810B; vecs[5].prog[1] = 16'h3201;
        vecs[5].prog[2] = 16'h4301; vecs[5].prog[3] = 16'h5401;
        vecs[5].prog[4] = 16'h6501; vecs[5].prog[5] = 16'hA210;
        vecs[5].prog[6] = 16'hA311; vecs[5].prog[7] = 16'hA412;
        vecs[5].prog[8] = 16'hA513; vecs[5].prog[9] = 16'hF000;
        vecs[5].seed_flag = 1'b1; vecs[5].seed = 8'h1D; vecs[5].lat = 1;
        vecs[5].n_acc = 4; vecs[5].cycles = 18; vecs[5].last_addr = 8'h0E;
        add_acc(5, 0, 2'b10, 8'h0B, 8'h3F);
        add_acc(5, 1, 2'b10, 8'h0C, 8'h09);
        add_acc(5, 2, 2'b10, 8'h0D, 8'h1F);
        add_acc(5, 3, 2'b10, 8'h0E, 8'h16);

        // 6: SUB wrap 2-5=FD, CMPGE false, then NOP/C/D/E to slot 15 and PC overflow
        vecs[6].prog[0] = 16'h8102; vecs[6].prog[1] = 16'h8205;
        vecs[6].prog[2] = 16'h2312; vecs[6].prog[3] = 16'h7412;
        vecs[6].prog[4] = 16'hA300; vecs[6].prog[5] = 16'hA401;
        vecs[6].prog[6] = 16'hC123; vecs[6].prog[7] = 16'hD456;
        vecs[6].prog[8] = 16'hE789;
        vecs[6].n_acc = 2; vecs[6].cycles = 19; vecs[6].last_addr = 8'h01;
        add_acc(6, 0, 2'b10, 8'h00, 8'hFD);
        add_acc(6, 1, 2'b10, 8'h01, 8'h00);

        // Reset state
        do_reset();
        chk("rst_ready", {31'd0, Ready}, 32'd1);
        chk("rst_en", {30'd0, mem_bus.enable_M}, 32'd0);
        chk("rst_addr", {24'd0, mem_bus.addr_M}, 32'd0);
        chk("rst_wdata", {24'd0, mem_bus.wr_data_M}, 32'd0);

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // Start / insn_data / seed changes during a stalled load are ignored
        do_reset();
        insn_data = '0;
        insn_data[15:0]  = 16'h9100;
        insn_data[31:16] = 16'hA101;
        insn_data[47:32] = 16'hF000;
        init_R0_flag = 1'b1; init_R0_data = 8'h07; Start = 1'b1;
        tick();
        Start = 1'b0; init_R0_flag = 1'b0;
        wait_req(ok);
        chk("busy_req_seen", {31'd0, ok}, 32'd1);
        chk("busy_ld_en", {30'd0, mem_bus.enable_M}, 32'd1);
        chk("busy_ld_addr", {24'd0, mem_bus.addr_M}, 32'h07);
        for (int i = 0; i < 16; i++) all_ready[i*16 +: 16] = 16'hF000;
        insn_data = all_ready;
        init_R0_flag = 1'b1; init_R0_data = 8'h40; Start = 1'b1;
        tick();
        Start = 1'b0; init_R0_flag = 1'b0;
        tick();
        chk("busy_stall_en", {30'd0, mem_bus.enable_M}, 32'd1);
        chk("busy_stall_ready", {31'd0, Ready}, 32'd0);
        mem_bus.ready_M = 1'b1; mem_bus.rd_data_M = 8'h5A;
        tick();
        mem_bus.ready_M = 1'b0;
        chk("busy_ld_done_en", {30'd0, mem_bus.enable_M}, 32'd0);
        tick();
        chk("busy_st_en", {30'd0, mem_bus.enable_M}, 32'd2);
        chk("busy_st_addr", {24'd0, mem_bus.addr_M}, 32'h08);
        chk("busy_st_wdata", {24'd0, mem_bus.wr_data_M}, 32'h5A);
        mem_bus.ready_M = 1'b1;
        tick();
        mem_bus.ready_M = 1'b0;
        chk("busy_st_done_ready", {31'd0, Ready}, 32'd0);
        tick();
        chk("busy_final_ready", {31'd0, Ready}, 32'd1);

        // Start held high: not taken on the edge where Ready rises
        do_reset();
        insn_data = '0;
        insn_data[15:0] = 16'hF000;
        Start = 1'b1;
        tick();
        chk("edge_accept1", {31'd0, Ready}, 32'd0);
        tick();
        chk("edge_ready_rise", {31'd0, Ready}, 32'd1);
        tick();
        chk("edge_accept2", {31'd0, Ready}, 32'd0);
        Start = 1'b0;
        tick();
        chk("edge_ready_again", {31'd0, Ready}, 32'd1);

        // Reset low while stalled in MEM
        do_reset();
        insn_data = '0;
        insn_data[15:0]  = 16'h9103;
        insn_data[31:16] = 16'hF000;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_req(ok);
        chk("mrst_req_seen", {31'd0, ok}, 32'd1);
        chk("mrst_addr_pre", {24'd0, mem_bus.addr_M}, 32'h03);
        tick();
        reset = 1'b0;
        tick();
        chk("mrst_ready", {31'd0, Ready}, 32'd1);
        chk("mrst_en", {30'd0, mem_bus.enable_M}, 32'd0);
        chk("mrst_addr", {24'd0, mem_bus.addr_M}, 32'd0);
        chk("mrst_wdata", {24'd0, mem_bus.wr_data_M}, 32'd0);
        reset = 1'b1;
        tick();
        chk("mrst_stay_idle", {31'd0, Ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
